// File: rtl/compare_seq_pkg.sv
// Shared types and width helpers for the compare sequencer.
// Holds the sequencer state encoding and a width function that never returns zero.
package compare_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_UUT,
        CMP,
        NEXT,
        DONE
    } seq_state_t;

    // Index width that stays at least one bit wide even when only one value exists.
    function automatic int unsigned min1_clog2(input int unsigned n);
        int unsigned w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/compare_sequencer_watchdog_timer.sv
// Watchdog counter for the UUT completion wait.
// expired goes high when the count reaches TIMEOUT_CYCLES-1 and the count holds there.
module watchdog_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    assign expired = (count == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/compare_sequencer.sv
// Test sequencer: launches the UUT per test, waits under a watchdog, then walks
// the per-test compare requests to the scoreboard and tallies pass/fail results.
module compare_sequencer
    import compare_seq_pkg::*;
#(
    parameter int unsigned NUM_TESTS       = 4,
    parameter int unsigned OUTPUT_ELEMENTS = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned IDX_W          = min1_clog2(NUM_TESTS * OUTPUT_ELEMENTS),
    localparam int unsigned TIDX_W         = min1_clog2(NUM_TESTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              uut_start,
    input  logic              uut_done,
    output logic              cmp_req,
    output logic [IDX_W-1:0]  cmp_idx,
    input  logic              cmp_ack,
    input  logic              cmp_pass,
    output logic [TIDX_W-1:0] test_idx,
    output logic              busy,
    output logic              done,
    output logic              status,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              timeout_err
);

    localparam int unsigned ELEM_W = min1_clog2(OUTPUT_ELEMENTS);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [ELEM_W-1:0] elem;
    logic              test_ok;
    logic              cmp_gap;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;
    logic              cmp_fire;
    logic              elem_last;
    logic              test_last;

    watchdog_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    assign elem_last = (elem == ELEM_W'(OUTPUT_ELEMENTS - 1));
    assign test_last = (test_idx == TIDX_W'(NUM_TESTS - 1));
    // cmp_gap forces the one-cycle drop of cmp_req between consecutive elements.
    assign cmp_fire  = (state == CMP) && !cmp_gap && cmp_ack;
    assign cmp_idx   = (state == CMP)
                     ? IDX_W'(test_idx) * IDX_W'(OUTPUT_ELEMENTS) + IDX_W'(elem)
                     : '0;
    assign status    = (state == DONE) && (pass_cnt == CNT_W'(NUM_TESTS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        uut_start   = 1'b0;
        cmp_req     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LAUNCH;
            end
            LAUNCH: begin
                uut_start   = 1'b1;
                timer_clear = 1'b1;
                state_next  = WAIT_UUT;
            end
            WAIT_UUT: begin
                timer_en = 1'b1;
                if (uut_done) begin
                    state_next = CMP;
                end else if (timer_expired) begin
                    state_next = NEXT;
                end
            end
            CMP: begin
                cmp_req = !cmp_gap;
                if (cmp_fire && elem_last) state_next = NEXT;
            end
            NEXT: begin
                state_next = test_last ? DONE : LAUNCH;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = LAUNCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            test_idx    <= '0;
            elem        <= '0;
            test_ok     <= 1'b0;
            cmp_gap     <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            cmp_gap <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        test_idx    <= '0;
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                WAIT_UUT: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (uut_done) begin
                        elem    <= '0;
                        test_ok <= 1'b1;
                    end else if (timer_expired) begin
                        test_ok     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                CMP: begin
                    if (cmp_fire) begin
                        test_ok <= test_ok & cmp_pass;
                        if (!elem_last) begin
                            elem    <= elem + ELEM_W'(1);
                            cmp_gap <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (test_ok) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                    if (!test_last) test_idx <= test_idx + TIDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
